ram_scan_reader: RTL and testbench

Read-side sequencer for the lab's 8-entry display RAMs. On start it walks the read address 0..7 and wraps, giving each entry a fixed dwell time or advancing one entry per step pulse. It accounts for the RAM's synchronous read latency and presents a stable address/data pair to the downstream hex decoders. It replaces manual read-address switches as the reader of a RAM whose write side is driven by switches.

---
 rtl/ram_scan_reader.sv | 103 ++++++++++
 tb/tb_ram_scan_reader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_scan_reader.sv
// Read-side sequencer for a small display RAM: walks the read address 0..2**AW-1
// and wraps, compensating for the RAM read latency before capturing each entry.
module ram_scan_reader #(
  parameter int AW     = 3,
  parameter int DW     = 8,
  parameter int DWELL  = 25_000_000,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          step_mode,
  input  logic          step,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [AW-1:0] cur_addr,
  output logic [DW-1:0] cur_data,
  output logic          data_valid,
  output logic          busy,
  output logic          wrap
);

  localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int LCW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } state_t;

  state_t           state_reg;
  logic [DCW-1:0]   dwell_cnt_reg;
  logic [LCW-1:0]   lat_cnt_reg;
  logic             advance;

  // In step mode the dwell counter is frozen and only a step pulse moves on.
  assign advance = (state_reg == HOLD) &&
                   (step_mode ? step : (dwell_cnt_reg == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      dwell_cnt_reg <= '0;
      lat_cnt_reg   <= '0;
      rd_addr       <= '0;
      cur_addr      <= '0;
      cur_data      <= '0;
      data_valid    <= 1'b0;
      busy          <= 1'b0;
      wrap          <= 1'b0;
    end else begin
      wrap <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && !stop) begin
            rd_addr     <= '0;
            lat_cnt_reg <= LCW'(RD_LAT);
            busy        <= 1'b1;
            state_reg   <= WAIT;
          end
        end

        WAIT: begin
          if (stop) begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end else if (lat_cnt_reg == '0) begin
            // rd_data now reflects rd_addr; this is the only edge it is sampled.
            cur_data      <= rd_data;
            cur_addr      <= rd_addr;
            data_valid    <= 1'b1;
            dwell_cnt_reg <= DCW'(DWELL - 1);
            state_reg     <= HOLD;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - LCW'(1);
          end
        end

        HOLD: begin
          if (stop) begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end else if (advance) begin
            rd_addr     <= rd_addr + AW'(1);
            wrap        <= (rd_addr == '1);
            lat_cnt_reg <= LCW'(RD_LAT);
            state_reg   <= WAIT;
          end else if (!step_mode) begin
            dwell_cnt_reg <= dwell_cnt_reg - DCW'(1);
          end
        end

        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_scan_reader.sv
// Directed bench for ram_scan_reader with a behavioural 8-entry RAM (1-cycle read)
// and a queue of expected captured entries.
module tb_ram_scan_reader;

  localparam int AW     = 3;
  localparam int DW     = 8;
  localparam int DWELL  = 4;
  localparam int RD_LAT = 1;
  // Capture-to-capture period in auto mode: DWELL cycles in HOLD, then RD_LAT+1 to capture.
  localparam int PERIOD = DWELL + RD_LAT + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          step_mode = 1'b0;
  logic          step = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_data;
  logic          data_valid;
  logic          busy;
  logic          wrap;

  logic [DW-1:0] mem [8];
  logic [AW+DW-1:0] sb_q [$];
  int checks = 0;
  int errors = 0;
  int wrap_cnt = 0;
  logic [AW-1:0] wrap_addr = '0;

  ram_scan_reader #(.AW(AW), .DW(DW), .DWELL(DWELL), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .step_mode(step_mode),
    .step(step), .rd_addr(rd_addr), .rd_data(rd_data), .cur_addr(cur_addr),
    .cur_data(cur_data), .data_valid(data_valid), .busy(busy), .wrap(wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];

  always @(negedge clk) begin
    if (wrap === 1'b1) begin
      wrap_cnt  = wrap_cnt + 1;
      wrap_addr = rd_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int a, input int d);
    sb_q.push_back({AW'(a), DW'(d)});
  endtask

  task automatic wait_capture(input string tag, input int budget, output int waited);
    logic [AW+DW:0] snap;
    logic [AW+DW-1:0] exp;
    bit seen;
    snap = {data_valid, cur_addr, cur_data};
    waited = 0;
    seen = 1'b0;
    while (!seen && waited < budget) begin
      tick();
      waited++;
      if ({data_valid, cur_addr, cur_data} !== snap) seen = 1'b1;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      exp = sb_q.pop_front();
      check({tag, "_addr"}, 32'(cur_addr), 32'(exp[AW+DW-1:DW]));
      check({tag, "_data"}, 32'(cur_data), 32'(exp[DW-1:0]));
      check({tag, "_valid"}, 32'(data_valid), 32'd1);
      $display("capture %s: addr=%0d data=%02h after %0d cycles", tag, cur_addr, cur_data, waited);
    end
  endtask

  initial begin
    int w;
    int bad;
    for (int i = 0; i < 8; i++) mem[i] = DW'(8'h10 + i);

    // 1. reset and first capture latency
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_cur_addr", 32'(cur_addr), 32'd0);
    check("rst_cur_data", 32'(cur_data), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);

    push(0, 8'h10);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_rd_addr", 32'(rd_addr), 32'd0);
    check("start_busy", 32'(busy), 32'd1);
    check("start_valid_early", 32'(data_valid), 32'd0);
    wait_capture("first", 10, w);
    check("first_latency", 32'(w), 32'(RD_LAT + 1));

    // 2. auto scan with wrap
    for (int i = 1; i < 8; i++) begin
      push(i, 8'h10 + i);
      wait_capture("auto", 20, w);
      check("auto_period", 32'(w), 32'(PERIOD));
    end
    check("no_wrap_before_7to0", 32'(wrap_cnt), 32'd0);
    push(0, 8'h10);
    push(1, 8'h11);
    push(2, 8'h12);
    for (int i = 0; i < 3; i++) begin
      wait_capture("auto_wrapped", 20, w);
      check("auto_wrapped_period", 32'(w), 32'(PERIOD));
    end
    check("wrap_once", 32'(wrap_cnt), 32'd1);
    check("wrap_at_addr0", 32'(wrap_addr), 32'd0);

    // 3. step mode in HOLD at address 2
    step_mode = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (cur_data !== 8'h12 || rd_addr !== 3'd2) bad++;
    end
    check("step_frozen_50", 32'(bad), 32'd0);
    check("step_frozen_data", 32'(cur_data), 32'h12);

    push(3, 8'h13);
    step = 1'b1;
    tick();
    step = 1'b0;
    wait_capture("step", 10, w);
    check("step_latency", 32'(w), 32'd2);

    push(4, 8'h14);
    step = 1'b1;
    tick();
    tick();
    step = 1'b0;
    wait_capture("step_in_wait", 10, w);
    check("step_in_wait_latency", 32'(w), 32'd1);
    for (int i = 0; i < 10; i++) tick();
    check("step_not_queued_addr", 32'(cur_addr), 32'd4);
    check("step_not_queued_rd", 32'(rd_addr), 32'd4);

    // 4. stop in HOLD at address 5
    push(5, 8'h15);
    step = 1'b1;
    tick();
    step = 1'b0;
    wait_capture("to5", 10, w);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_keep_data", 32'(cur_data), 32'h15);
    check("stop_keep_addr", 32'(cur_addr), 32'd5);
    check("stop_keep_valid", 32'(data_valid), 32'd1);
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    check("start_stop_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check("start_stop_idle_busy", 32'(busy), 32'd0);
    check("start_stop_idle_data", 32'(cur_data), 32'h15);

    // 5. restart from address 0; start while busy ignored
    push(0, 8'h10);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_capture("restart", 10, w);
    check("restart_latency", 32'(w), 32'd2);
    push(1, 8'h11);
    step = 1'b1;
    tick();
    step = 1'b0;
    wait_capture("restart_step", 10, w);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("busy_start_cur_addr", 32'(cur_addr), 32'd1);
    check("busy_start_rd_addr", 32'(rd_addr), 32'd1);
    step_mode = 1'b0;
    push(2, 8'h12);
    wait_capture("resume_auto", 20, w);

    // 6. reset while in WAIT at address 3
    step_mode = 1'b1;
    step = 1'b1;
    tick();
    step = 1'b0;
    check("pre_rst_rd_addr", 32'(rd_addr), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_rd_addr", 32'(rd_addr), 32'd0);
    check("midrst_cur_addr", 32'(cur_addr), 32'd0);
    check("midrst_cur_data", 32'(cur_data), 32'd0);
    check("midrst_valid", 32'(data_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_wrap", 32'(wrap), 32'd0);
    mem[3] = 8'hAA;
    mem[0] = 8'hBB;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cur_data !== 8'h00 || data_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("post_rst_no_capture", 32'(bad), 32'd0);
    check("wrap_total", 32'(wrap_cnt), 32'd1);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
